// File: rtl/count_monitor.sv
// Receiving-end checker for a WIDTH-bit up/down counter: verifies each Count/UD step,
// pulses Mismatch/Wrap, tracks lock and tallies errors. Optional macro COUNT_MON_HOLD_OK_EN.
module count_monitor #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int RESYNC = 2
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             Valid,
  input  logic             UD,
  input  logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] LastCount,
  output logic             Mismatch,
  output logic             Wrap,
  output logic             Locked,
  output logic [ERR_W-1:0] ErrCount,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [3:0]       RESYNC_GR = 4'(RESYNC);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       good_q, good_d;

  logic [WIDTH-1:0] exp_val;
  logic [3:0]       good_inc;
  logic             match;
  logic             is_wrap;
  logic             stall;

  assign exp_val  = UD ? (last_q + CNT_ONE) : (last_q - CNT_ONE);
  assign match    = (Count == exp_val);
  assign is_wrap  = UD ? (last_q == CNT_MAX) : (last_q == '0);
  assign good_inc = good_q + 4'd1;

`ifdef COUNT_MON_HOLD_OK_EN
  // A repeated value is a legal stall: nothing moves, nothing is counted.
  assign stall = (Count == last_q);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    last_d     = last_q;
    mismatch_d = 1'b0;
    wrap_d     = 1'b0;
    locked_d   = locked_q;
    err_d      = err_q;
    good_d     = good_q;

    if (Valid) begin
      case (state_q)
        TRACK, FAULT: begin
          if (!stall) begin
            last_d = Count;
            if (match) begin
              wrap_d = is_wrap;
              if (state_q == FAULT) begin
                if (good_inc == RESYNC_GR) begin
                  state_d  = TRACK;
                  locked_d = 1'b1;
                  good_d   = '0;
                end else begin
                  good_d = good_inc;
                end
              end
            end else begin
              mismatch_d = 1'b1;
              if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
              state_d  = FAULT;
              locked_d = 1'b0;
              good_d   = '0;
            end
          end
        end
        // SYNC and the unused encoding both anchor on the first valid sample.
        default: begin
          last_d   = Count;
          state_d  = TRACK;
          locked_d = 1'b1;
          good_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Clear) begin
      state_q    <= SYNC;
      last_q     <= '0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= '0;
      good_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      good_q     <= good_d;
    end
  end

  assign LastCount = last_q;
  assign Mismatch  = mismatch_q;
  assign Wrap      = wrap_q;
  assign Locked    = locked_q;
  assign ErrCount  = err_q;
  assign State     = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: default instance plus an ERR_W=2 instance for saturation.
module tb_count_monitor;

  logic       CLK;
  logic       Clear;
  logic       Valid;
  logic       UD;
  logic [3:0] Count;

  logic [3:0] last_count, last_count_s;
  logic       mismatch, mismatch_s;
  logic       wrap, wrap_s;
  logic       locked, locked_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;
  logic [1:0] state, state_s;

  int n_total = 0;
  int n_bad   = 0;

  count_monitor u_dut (
    .CLK(CLK), .Clear(Clear), .Valid(Valid), .UD(UD), .Count(Count),
    .LastCount(last_count), .Mismatch(mismatch), .Wrap(wrap),
    .Locked(locked), .ErrCount(err_count), .State(state)
  );

  count_monitor #(.ERR_W(2)) u_small (
    .CLK(CLK), .Clear(Clear), .Valid(Valid), .UD(UD), .Count(Count),
    .LastCount(last_count_s), .Mismatch(mismatch_s), .Wrap(wrap_s),
    .Locked(locked_s), .ErrCount(err_count_s), .State(state_s)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply one edge's inputs, then look at the registered outputs just after the edge.
  task automatic sample(input logic clr, input logic v, input logic ud, input logic [3:0] c);
    Clear = clr;
    Valid = v;
    UD    = ud;
    Count = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear();
    sample(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    Clear = 1'b1; Valid = 1'b0; UD = 1'b0; Count = 4'd0;

    // Reset state
    do_clear();
    check("rst_last", int'(last_count), 0);
    check("rst_mis", int'(mismatch), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_lock", int'(locked), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_state", int'(state), 0);

    // Up count 0..15,0
    sample(1'b0, 1'b1, 1'b1, 4'd0);
    check("up_anchor_lock", int'(locked), 1);
    check("up_anchor_state", int'(state), 1);
    check("up_anchor_wrap", int'(wrap), 0);
    for (int i = 1; i <= 16; i++) begin
      sample(1'b0, 1'b1, 1'b1, 4'(i));
      check("up_mis", int'(mismatch), 0);
      check("up_wrap", int'(wrap), (i == 16) ? 1 : 0);
    end
    sample(1'b0, 1'b0, 1'b1, 4'd0);
    check("up_wrap_clears", int'(wrap), 0);
    check("up_err", int'(err_count), 0);
    check("up_lock", int'(locked), 1);

    // Down count 2,1,0,15,14
    do_clear();
    sample(1'b0, 1'b1, 1'b0, 4'd2);
    sample(1'b0, 1'b1, 1'b0, 4'd1);
    check("dn_wrap1", int'(wrap), 0);
    sample(1'b0, 1'b1, 1'b0, 4'd0);
    check("dn_wrap0", int'(wrap), 0);
    sample(1'b0, 1'b1, 1'b0, 4'd15);
    check("dn_wrap15", int'(wrap), 1);
    check("dn_mis15", int'(mismatch), 0);
    sample(1'b0, 1'b1, 1'b0, 4'd14);
    check("dn_wrap14", int'(wrap), 0);
    check("dn_mis14", int'(mismatch), 0);
    check("dn_last", int'(last_count), 14);

    // Skip 3,4,6,7,8 with RESYNC=2
    do_clear();
    sample(1'b0, 1'b1, 1'b1, 4'd3);
    sample(1'b0, 1'b1, 1'b1, 4'd4);
    check("skip_mis4", int'(mismatch), 0);
    sample(1'b0, 1'b1, 1'b1, 4'd6);
    check("skip_mis6", int'(mismatch), 1);
    check("skip_err6", int'(err_count), 1);
    check("skip_state6", int'(state), 2);
    check("skip_lock6", int'(locked), 0);
    check("skip_last6", int'(last_count), 6);
    sample(1'b0, 1'b1, 1'b1, 4'd7);
    check("skip_mis7", int'(mismatch), 0);
    check("skip_state7", int'(state), 2);
    check("skip_lock7", int'(locked), 0);
    sample(1'b0, 1'b1, 1'b1, 4'd8);
    check("skip_state8", int'(state), 1);
    check("skip_lock8", int'(locked), 1);
    check("skip_err8", int'(err_count), 1);

    // Saturation on ERR_W=2: anchor 0, then five bad steps
    do_clear();
    sample(1'b0, 1'b1, 1'b1, 4'd0);
    sample(1'b0, 1'b1, 1'b1, 4'd5);
    check("sat_mis1", int'(mismatch_s), 1);
    check("sat_err1", int'(err_count_s), 1);
    sample(1'b0, 1'b1, 1'b1, 4'd9);
    check("sat_mis2", int'(mismatch_s), 1);
    check("sat_err2", int'(err_count_s), 2);
    sample(1'b0, 1'b1, 1'b1, 4'd2);
    check("sat_mis3", int'(mismatch_s), 1);
    check("sat_err3", int'(err_count_s), 3);
    sample(1'b0, 1'b1, 1'b1, 4'd12);
    check("sat_mis4", int'(mismatch_s), 1);
    check("sat_err4", int'(err_count_s), 3);
    sample(1'b0, 1'b1, 1'b1, 4'd7);
    check("sat_mis5", int'(mismatch_s), 1);
    check("sat_err5", int'(err_count_s), 3);
    check("sat_wide_err", int'(err_count), 5);
    check("sat_wrap_excl", int'(wrap_s), 0);

    // Valid=0 in FAULT holds everything, pulses drop
    sample(1'b0, 1'b0, 1'b1, 4'd3);
    check("hold_mis", int'(mismatch), 0);
    check("hold_state", int'(state), 2);
    check("hold_err", int'(err_count), 5);
    check("hold_last", int'(last_count), 7);

    // Clear overrides Valid while in FAULT
    sample(1'b1, 1'b1, 1'b1, 4'd3);
    check("clr_last", int'(last_count), 0);
    check("clr_mis", int'(mismatch), 0);
    check("clr_wrap", int'(wrap), 0);
    check("clr_lock", int'(locked), 0);
    check("clr_err", int'(err_count), 0);
    check("clr_state", int'(state), 0);
    sample(1'b0, 1'b1, 1'b1, 4'd9);
    check("clr_anchor_last", int'(last_count), 9);
    check("clr_anchor_lock", int'(locked), 1);
    check("clr_anchor_mis", int'(mismatch), 0);

    // Repeated value 5,5,6
    do_clear();
    sample(1'b0, 1'b1, 1'b1, 4'd5);
    sample(1'b0, 1'b1, 1'b1, 4'd5);
`ifdef COUNT_MON_HOLD_OK_EN
    check("rep_mis", int'(mismatch), 0);
    check("rep_err", int'(err_count), 0);
    check("rep_state", int'(state), 1);
`else
    check("rep_mis", int'(mismatch), 1);
    check("rep_err", int'(err_count), 1);
    check("rep_state", int'(state), 2);
`endif
    check("rep_wrap", int'(wrap), 0);
    sample(1'b0, 1'b1, 1'b1, 4'd6);
    check("rep_last", int'(last_count), 6);
    check("rep_mis6", int'(mismatch), 0);
`ifdef COUNT_MON_HOLD_OK_EN
    check("rep_err6", int'(err_count), 0);
`else
    check("rep_err6", int'(err_count), 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
